// File: rtl/dma_transfer_sequencer.sv
// dma_transfer_sequencer: single-channel 8237A-5 style transfer sequencer
// (SI/S0/S1/S2/S3/SW/S4, single-transfer mode). Holds the current address
// and word count, detects terminal count and external EOP.
// Optional build macro DMA_AUTOINIT_EN adds the i_autoinit input, which makes
// a terminal count reload the current registers from the base registers.
//
// state | meaning
// SI    | idle, waiting for an accepted request
// S0    | hold requested, waiting for HLDA
// S1    | address phase, ADSTB strobe, DACK asserted
// S2    | read strobe asserted
// S3    | write strobe asserted, READY sampled
// SW    | wait state, strobes held until READY
// S4    | transfer end, registers update on exit
module dma_transfer_sequencer #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_cs_n,
    input  logic              i_dreq_valid,
    input  logic [1:0]        i_channel,
    input  logic              i_hlda,
    input  logic              i_ready,
    input  logic              i_eop_in_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_base_count,
    input  logic [1:0]        i_xfer_type,
    input  logic              i_addr_dec,
`ifdef DMA_AUTOINIT_EN
    input  logic              i_autoinit,
`endif
    output logic              o_hrq,
    output logic              o_aen,
    output logic              o_adstb,
    output logic              o_memr_n,
    output logic              o_memw_n,
    output logic              o_ior_out_n,
    output logic              o_iow_out_n,
    output logic              o_io_drive_en,
    output logic [3:0]        o_dack,
    output logic [ADDR_W-1:0] o_addr_out,
    output logic              o_eop_out_n,
    output logic              o_tc,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_cur_addr,
    output logic [CNT_W-1:0]  o_cur_count
);

    typedef enum logic [2:0] {
        ST_SI = 3'd0,
        ST_S0 = 3'd1,
        ST_S1 = 3'd2,
        ST_S2 = 3'd3,
        ST_S3 = 3'd4,
        ST_SW = 3'd5,
        ST_S4 = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_channel;
    logic              r_eop_seen;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [CNT_W-1:0]  r_cur_count;
    logic              r_done;
    logic              r_tc;

    logic              r_hrq, r_aen, r_adstb, r_io_drive_en, r_eop_out_n;
    logic              r_memr_n, r_memw_n, r_ior_n, r_iow_n;
    logic [3:0]        r_dack;
    logic [ADDR_W-1:0] r_addr_out;

    logic              w_hrq, w_aen, w_adstb, w_io_drive_en, w_eop_out_n;
    logic              w_memr_n, w_memw_n, w_ior_n, w_iow_n;
    logic [3:0]        w_dack;
    logic [ADDR_W-1:0] w_addr_out;
    logic              w_in_xfer;
    logic              w_tc_cond;
    logic              w_is_read;
    logic              w_is_write;
    logic [ADDR_W-1:0] w_addr_step;

    assign w_in_xfer   = (r_state == ST_S1) || (r_state == ST_S2) || (r_state == ST_S3) ||
                         (r_state == ST_SW) || (r_state == ST_S4);
    // Current-cycle EOP counts too, so an EOP arriving in the last cycle is not lost.
    assign w_tc_cond   = (r_cur_count == '0) || r_eop_seen || !i_eop_in_n;
    assign w_is_read   = (i_xfer_type == 2'b10);
    assign w_is_write  = (i_xfer_type == 2'b01);
    assign w_addr_step = i_addr_dec ? (r_cur_addr - ADDR_W'(1)) : (r_cur_addr + ADDR_W'(1));

    // State register plus registered (Moore) bus outputs derived from the next state.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state       <= ST_SI;
            r_hrq         <= 1'b0;
            r_aen         <= 1'b0;
            r_adstb       <= 1'b0;
            r_io_drive_en <= 1'b0;
            r_dack        <= 4'b0000;
            r_memr_n      <= 1'b1;
            r_memw_n      <= 1'b1;
            r_ior_n       <= 1'b1;
            r_iow_n       <= 1'b1;
            r_eop_out_n   <= 1'b1;
            r_addr_out    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_hrq         <= w_hrq;
            r_aen         <= w_aen;
            r_adstb       <= w_adstb;
            r_io_drive_en <= w_io_drive_en;
            r_dack        <= w_dack;
            r_memr_n      <= w_memr_n;
            r_memw_n      <= w_memw_n;
            r_ior_n       <= w_ior_n;
            r_iow_n       <= w_iow_n;
            r_eop_out_n   <= w_eop_out_n;
            r_addr_out    <= w_addr_out;
        end
    end

    // Next-state decode and the output values the next state will present.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SI: if (!i_load && i_dreq_valid && i_cs_n && !r_done) w_state_nxt = ST_S0;
            ST_S0: begin
                if (i_hlda)             w_state_nxt = ST_S1;
                else if (!i_dreq_valid) w_state_nxt = ST_SI;
            end
            ST_S1: w_state_nxt = i_hlda ? ST_S2 : ST_SI;
            ST_S2: w_state_nxt = i_hlda ? ST_S3 : ST_SI;
            ST_S3, ST_SW: begin
                if (!i_hlda)      w_state_nxt = ST_SI;
                else if (i_ready) w_state_nxt = ST_S4;
                else              w_state_nxt = ST_SW;
            end
            ST_S4:   w_state_nxt = ST_SI;
            default: w_state_nxt = ST_SI;
        endcase

        w_hrq         = (w_state_nxt != ST_SI);
        w_aen         = 1'b0;
        w_io_drive_en = 1'b0;
        w_adstb       = (w_state_nxt == ST_S1);
        w_dack        = 4'b0000;
        w_addr_out    = '0;
        w_memr_n      = 1'b1;
        w_memw_n      = 1'b1;
        w_ior_n       = 1'b1;
        w_iow_n       = 1'b1;
        w_eop_out_n   = 1'b1;
        if ((w_state_nxt != ST_SI) && (w_state_nxt != ST_S0)) begin
            w_aen         = 1'b1;
            w_io_drive_en = 1'b1;
            w_dack        = 4'b0001 << r_channel;
            w_addr_out    = r_cur_addr;
            if (w_state_nxt != ST_S1) begin
                w_memr_n = !w_is_read;
                w_ior_n  = !w_is_write;
            end
            if ((w_state_nxt == ST_S3) || (w_state_nxt == ST_SW) || (w_state_nxt == ST_S4)) begin
                w_iow_n  = !w_is_read;
                w_memw_n = !w_is_write;
            end
            if (w_state_nxt == ST_S4) w_eop_out_n = !w_tc_cond;
        end
    end

    // Channel latch, EOP capture, LOAD, and the end-of-transfer register update.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_channel   <= 2'b00;
            r_eop_seen  <= 1'b0;
            r_cur_addr  <= '0;
            r_cur_count <= '0;
            r_done      <= 1'b0;
            r_tc        <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if ((r_state == ST_SI) && (w_state_nxt == ST_S0)) r_channel <= i_channel;
            if (w_state_nxt == ST_SI)             r_eop_seen <= 1'b0;
            else if (w_in_xfer && !i_eop_in_n)    r_eop_seen <= 1'b1;
            if ((r_state == ST_SI) && i_load) begin
                r_cur_addr  <= i_base_addr;
                r_cur_count <= i_base_count;
                r_done      <= 1'b0;
            end
            if (r_state == ST_S4) begin
                r_tc <= w_tc_cond;
`ifdef DMA_AUTOINIT_EN
                if (w_tc_cond && i_autoinit) begin
                    r_cur_addr  <= i_base_addr;
                    r_cur_count <= i_base_count;
                end else begin
                    r_cur_addr  <= w_addr_step;
                    r_cur_count <= r_cur_count - CNT_W'(1);
                    if (w_tc_cond) r_done <= 1'b1;
                end
`else
                r_cur_addr  <= w_addr_step;
                r_cur_count <= r_cur_count - CNT_W'(1);
                if (w_tc_cond) r_done <= 1'b1;
`endif
            end
        end
    end

    assign o_hrq         = r_hrq;
    assign o_aen         = r_aen;
    assign o_adstb       = r_adstb;
    assign o_io_drive_en = r_io_drive_en;
    assign o_dack        = r_dack;
    assign o_memr_n      = r_memr_n;
    assign o_memw_n      = r_memw_n;
    assign o_ior_out_n   = r_ior_n;
    assign o_iow_out_n   = r_iow_n;
    assign o_eop_out_n   = r_eop_out_n;
    assign o_addr_out    = r_addr_out;
    assign o_tc          = r_tc;
    assign o_done        = r_done;
    assign o_cur_addr    = r_cur_addr;
    assign o_cur_count   = r_cur_count;

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Directed bench for dma_transfer_sequencer. Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped when the DUT is sampled.
// Sampling and driving happen 1 ns after each rising edge.
module tb_dma_transfer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        dreq = 1'b0;
    logic [1:0]  ch = 2'd0;
    logic        hlda = 1'b0;
    logic        ready = 1'b1;
    logic        eop_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] base_a = 16'h0;
    logic [15:0] base_c = 16'h0;
    logic [1:0]  xt = 2'b00;
    logic        dec = 1'b0;
`ifdef DMA_AUTOINIT_EN
    logic        autoinit = 1'b0;
`endif

    logic        o_hrq, o_aen, o_adstb, o_memr_n, o_memw_n, o_ior_out_n, o_iow_out_n;
    logic        o_io_drive_en, o_eop_out_n, o_tc, o_done;
    logic [3:0]  o_dack;
    logic [15:0] o_addr_out, o_cur_addr, o_cur_count;

    dma_transfer_sequencer #(.ADDR_W(16), .CNT_W(16)) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_cs_n       (cs_n),
        .i_dreq_valid (dreq),
        .i_channel    (ch),
        .i_hlda       (hlda),
        .i_ready      (ready),
        .i_eop_in_n   (eop_n),
        .i_load       (load),
        .i_base_addr  (base_a),
        .i_base_count (base_c),
        .i_xfer_type  (xt),
        .i_addr_dec   (dec),
`ifdef DMA_AUTOINIT_EN
        .i_autoinit   (autoinit),
`endif
        .o_hrq        (o_hrq),
        .o_aen        (o_aen),
        .o_adstb      (o_adstb),
        .o_memr_n     (o_memr_n),
        .o_memw_n     (o_memw_n),
        .o_ior_out_n  (o_ior_out_n),
        .o_iow_out_n  (o_iow_out_n),
        .o_io_drive_en(o_io_drive_en),
        .o_dack       (o_dack),
        .o_addr_out   (o_addr_out),
        .o_eop_out_n  (o_eop_out_n),
        .o_tc         (o_tc),
        .o_done       (o_done),
        .o_cur_addr   (o_cur_addr),
        .o_cur_count  (o_cur_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic ex(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic ck(input logic [31:0] a);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h, no expected entry", a);
        end else begin
            e = q.pop_front();
            assert (a === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, a, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle();
        ex("hrq", 0); ex("aen", 0); ex("adstb", 0); ex("io_drive_en", 0); ex("dack", 0);
        ex("memr_n", 1); ex("memw_n", 1); ex("ior_n", 1); ex("iow_n", 1);
        ex("eop_out_n", 1); ex("addr_out", 0); ex("tc", 0); ex("done", 0);
        ex("cur_addr", 0); ex("cur_count", 0);
        ck(o_hrq); ck(o_aen); ck(o_adstb); ck(o_io_drive_en); ck(o_dack);
        ck(o_memr_n); ck(o_memw_n); ck(o_ior_out_n); ck(o_iow_out_n);
        ck(o_eop_out_n); ck(o_addr_out); ck(o_tc); ck(o_done);
        ck(o_cur_addr); ck(o_cur_count);
    endtask

    // Entered with the DUT in S0 and HLDA high; leaves it observed in SI.
    task automatic xfer(input logic [15:0] a, input logic [1:0] c, input logic tc_exp,
                        input logic [15:0] a_nxt, input logic [15:0] c_nxt, input logic done_exp);
        ex("s1_aen", 1); ex("s1_adstb", 1); ex("s1_dack", 4'b0001 << c); ex("s1_addr_out", a);
        step();
        ck(o_aen); ck(o_adstb); ck(o_dack); ck(o_addr_out);
        ex("s2_memr_n", !(xt == 2'b10)); ex("s2_ior_n", !(xt == 2'b01)); ex("s2_adstb", 0);
        step();
        ck(o_memr_n); ck(o_ior_out_n); ck(o_adstb);
        ex("s3_memr_n", !(xt == 2'b10)); ex("s3_iow_n", !(xt == 2'b10)); ex("s3_memw_n", !(xt == 2'b01));
        step();
        ck(o_memr_n); ck(o_iow_out_n); ck(o_memw_n);
        ex("s4_eop_out_n", !tc_exp); ex("s4_hrq", 1); ex("s4_aen", 1); ex("s4_iow_n", !(xt == 2'b10));
        step();
        ck(o_eop_out_n); ck(o_hrq); ck(o_aen); ck(o_iow_out_n);
        ex("end_tc", tc_exp); ex("end_cur_addr", a_nxt); ex("end_cur_count", c_nxt);
        ex("end_done", done_exp); ex("end_hrq", 0); ex("end_memr_n", 1); ex("end_dack", 0);
        step();
        ck(o_tc); ck(o_cur_addr); ck(o_cur_count); ck(o_done); ck(o_hrq); ck(o_memr_n); ck(o_dack);
    endtask

    task automatic load_regs(input logic [15:0] a, input logic [15:0] c);
        base_a = a;
        base_c = c;
        load = 1'b1;
        step();
        load = 1'b0;
        ex("load_addr", a); ex("load_count", c); ex("load_done", 0);
        ck(o_cur_addr); ck(o_cur_count); ck(o_done);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // power-up reset
        step(); step();
        chk_idle();
        rst_n = 1'b1;
        step();

        // read transfers: LOAD with a simultaneous request, LOAD must win
        ch = 2'd1; xt = 2'b10; dec = 1'b0;
        base_a = 16'h1000; base_c = 16'd2; load = 1'b1; dreq = 1'b1;
        step();
        ex("load_wins_hrq", 0); ex("load_cur_addr", 16'h1000); ex("load_cur_count", 2);
        ck(o_hrq); ck(o_cur_addr); ck(o_cur_count);
        load = 1'b0;
        step();
        ex("req_hrq", 1); ex("s0_aen", 0); ck(o_hrq); ck(o_aen);
        hlda = 1'b1;
        xfer(16'h1000, 2'd1, 1'b0, 16'h1001, 16'd1, 1'b0);
        step(); ex("b2b_hrq", 1); ck(o_hrq);
        xfer(16'h1001, 2'd1, 1'b0, 16'h1002, 16'd0, 1'b0);
        step(); ex("b2b_hrq", 1); ck(o_hrq);
        xfer(16'h1002, 2'd1, 1'b1, 16'h1003, 16'hFFFF, 1'b1);
        step();
        ex("tc_one_cycle", 0); ex("done_blocks_hrq", 0); ex("done_held", 1);
        ck(o_tc); ck(o_hrq); ck(o_done);
        dreq = 1'b0; hlda = 1'b0;

        // write transfer with three wait states
        ch = 2'd2; xt = 2'b01;
        load_regs(16'h2000, 16'd5);
        dreq = 1'b1;
        step(); ex("w_hrq", 1); ck(o_hrq);
        hlda = 1'b1;
        step(); ex("w_s1_addr", 16'h2000); ex("w_s1_dack", 4'b0100); ck(o_addr_out); ck(o_dack);
        step(); ex("w_s2_ior_n", 0); ex("w_s2_memw_n", 1); ck(o_ior_out_n); ck(o_memw_n);
        ready = 1'b0;
        step(); ex("w_s3_ior_n", 0); ex("w_s3_memw_n", 0); ck(o_ior_out_n); ck(o_memw_n);
        for (int i = 0; i < 3; i++) begin
            step();
            ex("sw_memw_n", 0); ex("sw_ior_n", 0); ex("sw_cur_addr", 16'h2000); ex("sw_eop_out_n", 1);
            ck(o_memw_n); ck(o_ior_out_n); ck(o_cur_addr); ck(o_eop_out_n);
            if (i == 2) ready = 1'b1;
        end
        step(); ex("w_s4_memw_n", 0); ex("w_s4_aen", 1); ck(o_memw_n); ck(o_aen);
        dreq = 1'b0;
        step();
        ex("w_end_count", 16'd4); ex("w_end_addr", 16'h2001); ex("w_end_memw_n", 1); ex("w_end_tc", 0);
        ck(o_cur_count); ck(o_cur_addr); ck(o_memw_n); ck(o_tc);
        hlda = 1'b0;
        step();
        ex("w_count_once", 16'd4); ck(o_cur_count);

        // external EOP during S2 of a verify transfer
        ch = 2'd3; xt = 2'b00;
        load_regs(16'h3000, 16'd5);
        dreq = 1'b1;
        step(); hlda = 1'b1;
        step(); ex("e_s1_dack", 4'b1000); ck(o_dack);
        step(); ex("e_s2_memr_n", 1); ex("e_s2_ior_n", 1); ck(o_memr_n); ck(o_ior_out_n);
        eop_n = 1'b0;
        step(); eop_n = 1'b1;
        ex("e_s3_memw_n", 1); ex("e_s3_iow_n", 1); ex("e_s3_eop_out_n", 1);
        ck(o_memw_n); ck(o_iow_out_n); ck(o_eop_out_n);
        step(); ex("e_s4_eop_out_n", 0); ck(o_eop_out_n);
        dreq = 1'b0;
        step();
        ex("e_tc", 1); ex("e_done", 1); ex("e_count", 16'd4); ex("e_addr", 16'h3001);
        ck(o_tc); ck(o_done); ck(o_cur_count); ck(o_cur_addr);
        hlda = 1'b0;
        step(); ex("e_tc_pulse", 0); ck(o_tc);

        // abort: HLDA dropped in S2
        ch = 2'd0; xt = 2'b10;
        load_regs(16'h4000, 16'd3);
        dreq = 1'b1;
        step(); hlda = 1'b1;
        step();
        step(); ex("a_s2_memr_n", 0); ck(o_memr_n);
        hlda = 1'b0;
        step();
        dreq = 1'b0;
        ex("a_hrq", 0); ex("a_aen", 0); ex("a_memr_n", 1); ex("a_dack", 0);
        ex("a_addr", 16'h4000); ex("a_count", 16'd3); ex("a_tc", 0);
        ck(o_hrq); ck(o_aen); ck(o_memr_n); ck(o_dack); ck(o_cur_addr); ck(o_cur_count); ck(o_tc);
        step(); ex("a_tc_later", 0); ex("a_done", 0); ck(o_tc); ck(o_done);

        // address decrement wrap
        ch = 2'd1; xt = 2'b10; dec = 1'b1;
        load_regs(16'h0000, 16'd1);
        dreq = 1'b1;
        step(); hlda = 1'b1;
        xfer(16'h0000, 2'd1, 1'b0, 16'hFFFF, 16'd0, 1'b0);
        step(); ex("wrap_hrq", 1); ck(o_hrq);
        xfer(16'hFFFF, 2'd1, 1'b1, 16'hFFFE, 16'hFFFF, 1'b1);
        dreq = 1'b0; hlda = 1'b0; dec = 1'b0;
        step();

`ifdef DMA_AUTOINIT_EN
        // autoinit reload at terminal count
        ch = 2'd2; xt = 2'b10; autoinit = 1'b1;
        load_regs(16'h0200, 16'd0);
        dreq = 1'b1;
        step(); hlda = 1'b1;
        xfer(16'h0200, 2'd2, 1'b1, 16'h0200, 16'd0, 1'b0);
        step(); ex("ai_next_req", 1); ck(o_hrq);
        dreq = 1'b0; hlda = 1'b0; autoinit = 1'b0;
        step(); step();
`endif

        // reset asserted for two cycles while in S3
        xt = 2'b10;
        load_regs(16'h5000, 16'd7);
        dreq = 1'b1;
        step(); hlda = 1'b1;
        step();
        step();
        step(); ex("r_s3_memr_n", 0); ex("r_s3_iow_n", 0); ck(o_memr_n); ck(o_iow_out_n);
        rst_n = 1'b0;
        step(); step();
        chk_idle();
        rst_n = 1'b1; dreq = 1'b0; hlda = 1'b0;
        step();
        ex("post_reset_hrq", 0); ck(o_hrq);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_transfer_sequencer.md
# dma_transfer_sequencer

- Single-channel transfer sequencer for the 8237A-5 DMA controller. It runs the SI/S0/S1/S2/S3/SW/S4 state machine for single-transfer mode.
- It requests the bus, drives the AEN/ADSTB/strobe/DACK pattern for each transfer, and holds and updates the current address and word count.
- It detects terminal count and external EOP.
- It sits between the priority block (winning request and channel) and the external bus pins; the datapath block drives the address/data tri-states from this block's outputs.

## Interface
Parameters:
- ADDR_W, 16, current/base address width
- CNT_W, 16, word count width

Ports:
- CLOCK  in  1  system clock; all state changes on rising edge
- RESET  in  1  one clock; reset is synchronous and active-low
- CS_N  in  1  CPU programming access; while low, no new request is accepted in SI
- DREQ_VALID  in  1  priority block has a pending request
- CHANNEL  in  2  channel that won priority; latched on SI→S0
- HLDA  in  1  hold acknowledge from CPU
- READY  in  1  slow-device ready; sampled at end of S3/SW
- EOP_IN_N  in  1  external end-of-process, active low
- LOAD  in  1  copy BASE_ADDR/BASE_COUNT into current registers and clear DONE; honoured only in SI
- BASE_ADDR  in  ADDR_W  programmed start address
- BASE_COUNT  in  CNT_W  programmed word count (transfers = count+1)
- XFER_TYPE  in  2  00 verify, 01 write (IOR→MEMW), 10 read (MEMR→IOW), 11 illegal, treated as verify
- ADDR_DEC  in  1  1 = decrement address after each transfer
- HRQ  out  1  hold request
- AEN  out  1  address enable
- ADSTB  out  1  upper-address strobe
- MEMR_N, MEMW_N  out  1 each  memory strobes
- IOR_OUT_N, IOW_OUT_N  out  1 each  I/O strobes
- IO_DRIVE_EN  out  1  datapath drives IOR_N/IOW_N/ADDRESS pins
- DACK  out  4  one-hot acknowledge for the latched channel
- ADDR_OUT  out  ADDR_W  current address presented on the bus
- EOP_OUT_N  out  1  terminal-count indication, active low
- TC  out  1  one-cycle pulse at transfer end when count expired or EOP_IN_N seen
- DONE  out  1  channel finished; blocks new requests until LOAD
- CUR_ADDR  out  ADDR_W  current address register
- CUR_COUNT  out  CNT_W  current count register

## Operation
States and transitions:
- SI: transfers to S0 when DREQ_VALID & CS_N & !DONE. Otherwise stays in SI.
- S0: HRQ=1.
  - HLDA=1 → S1.
  - DREQ_VALID=0 → SI (request withdrawn).
- S1: AEN=1, IO_DRIVE_EN=1, ADSTB=1 (this cycle only), DACK[CHANNEL]=1; ADDR_OUT=CUR_ADDR. Next state S2.
- S2: read strobe asserted (MEMR_N for read, IOR_OUT_N for write, none for verify). Next state S3.
- S3: write strobe asserted (IOW_OUT_N for read, MEMW_N for write).
  - READY=1 → S4.
  - READY=0 → SW.
- SW: strobes held. Stays in SW while READY=0; goes to S4 when READY=1.
- S4: strobes still asserted. Next state SI, which deasserts all outputs.
- HRQ, AEN and DACK stay asserted from S1 through S4.

Register update on the S4→SI edge:
- CUR_ADDR ±1, modulo 2^ADDR_W: FFFF+1→0000, 0000−1→FFFF.
- CUR_COUNT −1, modulo 2^CNT_W.

Terminal count and EOP:
- TC condition: CUR_COUNT==0 in S4, or EOP_IN_N=0 sampled in any of S1..S4/SW. The EOP sample is latched until S4.
- On TC condition: EOP_OUT_N=0 during S4, TC=1 on the S4→SI edge, DONE=1. Registers still update.
- EOP_IN_N does not cut a transfer short; the current transfer always completes.

Abort and simultaneous events:
- HLDA dropping in S1..SW: abort to SI next cycle, all outputs inactive, no register update, no TC.
- LOAD outside SI is ignored.
- LOAD and DREQ_VALID in the same SI cycle: LOAD wins; the request is accepted the following cycle.
- RESET=0 in any state: SI on the next edge.

## Timing
- Reset values:
  - HRQ=0, AEN=0, ADSTB=0, IO_DRIVE_EN=0, DACK=0000, TC=0, DONE=0.
  - MEMR_N=1, MEMW_N=1, IOR_OUT_N=1, IOW_OUT_N=1, EOP_OUT_N=1.
  - CUR_ADDR=0, CUR_COUNT=0, ADDR_OUT=0.
- All outputs are registered (Moore); there is no combinational path from input to output.
- Latency with HLDA granted at the first S0 cycle and READY high:
  - DREQ_VALID seen → HRQ after 1 cycle.
  - HRQ → S1 one cycle after HLDA.
  - One transfer = S1..S4 = 4 cycles, plus 1 per wait cycle.
- Back-to-back: after S4 the block returns to SI for exactly one cycle (HRQ low), then re-requests if DREQ_VALID is still high.

## Configuration
- DMA_AUTOINIT_EN defined:
  - Adds input AUTOINIT (1 bit).
  - With AUTOINIT=1 at a TC condition, the S4→SI edge reloads CUR_ADDR/CUR_COUNT from BASE_ADDR/BASE_COUNT instead of stepping them. TC still pulses, and DONE stays 0.
- DMA_AUTOINIT_EN undefined:
  - No AUTOINIT port.
  - Every TC condition sets DONE, and only LOAD clears it.

## Test plan
- Reset: drive RESET=0 for 2 cycles in state S3 → all outputs at reset values, state SI.
- Read transfer:
  - Setup: LOAD with BASE_ADDR=0x1000, BASE_COUNT=2, XFER_TYPE=10, CHANNEL=1; HLDA returned 1 cycle after HRQ.
  - Expect 3 transfers: MEMR_N low for S2..S4, IOW_OUT_N low for S3..S4, DACK=0010.
  - Expect ADDR_OUT 0x1000, 0x1001, 0x1002.
  - On the third transfer: EOP_OUT_N low in S4, TC pulse, DONE=1, CUR_COUNT=0xFFFF.
- Wait states: READY held 0 for 3 cycles in S3 → SW for 3 cycles with strobes held; transfer length 7 cycles; registers update once.
- Address wrap: ADDR_DEC=1, BASE_ADDR=0x0000, BASE_COUNT=1 → ADDR_OUT 0x0000 then 0xFFFF.
- External EOP and abort:
  - EOP_IN_N pulsed low in S2 with CUR_COUNT=5 → transfer completes, TC=1, DONE=1, CUR_COUNT=4.
  - Separate run: HLDA dropped in S2 → SI next cycle, CUR_ADDR unchanged, no TC.
- Autoinit (with DMA_AUTOINIT_EN, AUTOINIT=1, BASE_COUNT=0, BASE_ADDR=0x0200) → TC pulse; CUR_ADDR reloaded to 0x0200 and CUR_COUNT to 0; DONE=0; next request serviced.
